eth_fcs_checker: RTL

Byte-parallel, parametrised Ethernet FCS (CRC-32) checker that succeeds the bit-serial checker on the receive path. It consumes a beat-oriented frame stream of `BYTES` bytes per cycle. It optionally strips a fixed-length preamble/SFD prefix and computes CRC-32 over the remaining bytes, including the trailing FCS. At end of frame it reports good/bad FCS, runt, abort, length and a running error count to the switch's frame-accept logic.

---
 rtl/eth_fcs_checker_if.sv | 19 +
 rtl/eth_fcs_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_checker_if.sv
// Beat-oriented receive frame stream feeding the FCS checker.
// No backpressure: every valid beat is consumed.
interface eth_fcs_checker_if #(
  parameter int BYTES = 1
) ();
  logic                     in_valid;
  logic [8*BYTES-1:0]       in_data;
  logic                     in_sof;
  logic                     in_eof;
  logic [$clog2(BYTES):0]   in_nbytes;

  modport master (
    output in_valid, in_data, in_sof, in_eof, in_nbytes
  );

  modport slave (
    input in_valid, in_data, in_sof, in_eof, in_nbytes
  );
endinterface

// File: rtl/eth_fcs_checker.sv
// Byte-parallel Ethernet FCS (reflected CRC-32) checker with
// optional preamble skip, runt/abort detection and error count.
module eth_fcs_checker #(
  parameter int BYTES      = 1,
  parameter int SKIP_BYTES = 8,
  parameter int MIN_BYTES  = 64
) (
  input  logic                clk,
  input  logic                reset,
  eth_fcs_checker_if.slave    s,
  output logic                out_done,
  output logic                out_fcs_error,
  output logic                out_runt,
  output logic                out_abort,
  output logic [15:0]         out_length,
  output logic [31:0]         out_crc,
  output logic [15:0]         err_count
);

  localparam int NBW        = $clog2(BYTES) + 1;
  localparam int SKIP_BEATS = SKIP_BYTES / BYTES;
  localparam int CW         = (SKIP_BEATS > 1) ? $clog2(SKIP_BEATS + 1) : 1;

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] INIT    = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    CRC
  } state_t;

  typedef struct packed {
    logic        fcs_error;
    logic        runt;
    logic        abort;
    logic [15:0] length;
    logic [31:0] crc;
  } res_t;

  state_t          state_q, state_d;
  logic [31:0]     crc_q, crc_d;
  logic [15:0]     len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_v_q, pend_v_d;
  res_t            pend_q, pend_d;

  logic            a_v, b_v, emit_v;
  res_t            a_r, b_r, emit_r;
  logic [NBW-1:0]  lanes;
  logic [31:0]     crc_cont, crc_new;

  function automatic logic [31:0] crc_beat(
    input logic [31:0]        c_in,
    input logic [8*BYTES-1:0] d,
    input logic [NBW-1:0]     n
  );
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int l = 0; l < BYTES; l++) begin
      if (l < int'(n)) begin
        for (int b = 0; b < 8; b++) begin
          fb = c[0] ^ d[8*l+b];
          c  = {1'b0, c[31:1]} ^ (fb ? POLY : 32'd0);
        end
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] len_add(
    input logic [15:0]    len,
    input logic [NBW-1:0] n
  );
    logic [16:0] sum;
    sum = {1'b0, len} + 17'(n);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic res_t mk_res(
    input logic [15:0] len,
    input logic [31:0] crc,
    input logic        abort
  );
    res_t r;
    r.length    = len;
    r.crc       = crc;
    r.abort     = abort;
    r.runt      = (MIN_BYTES > 0) &&
                  ({16'd0, len} < 32'(MIN_BYTES));
    r.fcs_error = abort | r.runt | (crc != RESIDUE);
    return r;
  endfunction

  assign lanes    = s.in_eof ? s.in_nbytes : NBW'(BYTES);
  assign crc_cont = crc_beat(crc_q, s.in_data, lanes);
  assign crc_new  = crc_beat(INIT, s.in_data, lanes);

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    a_v     = 1'b0;
    a_r     = '0;
    b_v     = 1'b0;
    b_r     = '0;
    if (s.in_valid) begin
      if (s.in_sof) begin
        if (state_q != IDLE) begin
          a_v = 1'b1;
          a_r = mk_res(len_q, crc_q, 1'b1);
        end
        if (SKIP_BEATS == 0) begin
          crc_d = crc_new;
          len_d = len_add(16'd0, lanes);
          if (s.in_eof) begin
            b_v     = 1'b1;
            b_r     = mk_res(len_d, crc_d, 1'b0);
            state_d = IDLE;
          end else begin
            state_d = CRC;
          end
        end else begin
          crc_d = INIT;
          len_d = 16'd0;
          cnt_d = CW'(1);
          if (s.in_eof) begin
            b_v     = 1'b1;
            b_r     = mk_res(16'd0, INIT, 1'b0);
            state_d = IDLE;
          end else if (SKIP_BEATS == 1) begin
            state_d = CRC;
          end else begin
            state_d = SKIP;
          end
        end
      end else begin
        unique case (state_q)
          IDLE: ;
          SKIP: begin
            cnt_d = cnt_q + 1'b1;
            if (s.in_eof) begin
              b_v     = 1'b1;
              b_r     = mk_res(16'd0, INIT, 1'b0);
              state_d = IDLE;
            end else if (cnt_d == CW'(SKIP_BEATS)) begin
              state_d = CRC;
            end
          end
          CRC: begin
            crc_d = crc_cont;
            len_d = len_add(len_q, lanes);
            if (s.in_eof) begin
              b_v     = 1'b1;
              b_r     = mk_res(len_d, crc_d, 1'b0);
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // A pending result always goes out first; a pending slot only exists
  // after a returning-to-IDLE beat, so an abort can never collide with it.
  always_comb begin
    emit_v   = 1'b0;
    emit_r   = a_r;
    pend_v_d = 1'b0;
    pend_d   = pend_q;
    if (pend_v_q) begin
      emit_v   = 1'b1;
      emit_r   = pend_q;
      pend_v_d = a_v | b_v;
      pend_d   = a_v ? a_r : b_r;
    end else if (a_v) begin
      emit_v   = 1'b1;
      emit_r   = a_r;
      pend_v_d = b_v;
      pend_d   = b_r;
    end else if (b_v) begin
      emit_v = 1'b1;
      emit_r = b_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      crc_q    <= INIT;
      len_q    <= 16'd0;
      cnt_q    <= '0;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_done      <= 1'b0;
      out_fcs_error <= 1'b0;
      out_runt      <= 1'b0;
      out_abort     <= 1'b0;
      out_length    <= 16'd0;
      out_crc       <= INIT;
      err_count     <= 16'd0;
    end else begin
      out_done <= emit_v;
      if (emit_v) begin
        out_fcs_error <= emit_r.fcs_error;
        out_runt      <= emit_r.runt;
        out_abort     <= emit_r.abort;
        out_length    <= emit_r.length;
        out_crc       <= emit_r.crc;
        if (emit_r.fcs_error && err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
      end
    end
  end

endmodule
